// File: rtl/score_keeper.sv
// score_keeper
//   Game-state and scoring controller for Flappy Bird. Runs IDLE -> PLAY ->
//   OVER, counts pipe passes with saturation, keeps a session high score and
//   enforces a hold-off period in OVER before a restart is accepted.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   start      in   start/flap button level (synchronised to clk)
//   pipe_pass  in   high while the bird is past a pipe gap; rising edge scores
//   collision  in   high while the bird overlaps pipe/ground/ceiling
//   score      out  current score (registered, saturates at MAX_SCORE)
//   gameover   out  high in OVER (registered)
//   playing    out  high in PLAY (registered)
//   high_score out  best score since reset (registered)
//   new_best   out  high in OVER when the finished game set a new high score
module score_keeper #(
  parameter int SCORE_W     = 10,
  parameter int MAX_SCORE   = 999,
  parameter int HOLD_CYCLES = 50000000,
  parameter int HOLD_W      = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pipe_pass,
  input  logic               collision,
  output logic [SCORE_W-1:0] score,
  output logic               gameover,
  output logic               playing,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_best
);

  localparam logic [SCORE_W-1:0] MAX_S     = SCORE_W'(MAX_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   high_q, high_d;
  logic                 gameover_q, gameover_d;
  logic                 playing_q, playing_d;
  logic                 new_best_q, new_best_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 start_q, pipe_q;
  logic                 start_rise, pipe_rise;

  // Saturating increment: the display cannot render beyond MAX_SCORE.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    if (v < MAX_S) begin
      return v + 1'b1;
    end
    return MAX_S;
  endfunction

  assign start_rise = start & ~start_q;
  assign pipe_rise  = pipe_pass & ~pipe_q;

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    gameover_d = gameover_q;
    playing_d  = playing_q;
    new_best_d = new_best_q;
    hold_d     = hold_q;

    case (state_q)
      IDLE: begin
        playing_d  = 1'b0;
        gameover_d = 1'b0;
        score_d    = '0;
        if (start_rise) begin
          state_d    = PLAY;
          playing_d  = 1'b1;
          new_best_d = 1'b0;
        end
      end

      PLAY: begin
        // Collision wins over a simultaneous pipe edge: the point is lost.
        if (collision) begin
          state_d    = OVER;
          gameover_d = 1'b1;
          playing_d  = 1'b0;
          hold_d     = HOLD_INIT;
          if (score_q > high_q) begin
            high_d     = score_q;
            new_best_d = 1'b1;
          end else begin
            new_best_d = 1'b0;
          end
        end else if (pipe_rise) begin
          score_d = sat_inc(score_q);
        end
      end

      OVER: begin
        // A press during hold-off is swallowed; because edges come from
        // start_q, a still-held button cannot restart once the count ends.
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (start_rise) begin
          state_d    = PLAY;
          score_d    = '0;
          gameover_d = 1'b0;
          playing_d  = 1'b1;
          new_best_d = 1'b0;
        end
      end

      default: begin
        state_d    = IDLE;
        score_d    = '0;
        gameover_d = 1'b0;
        playing_d  = 1'b0;
        new_best_d = 1'b0;
        hold_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      score_q    <= '0;
      high_q     <= '0;
      gameover_q <= 1'b0;
      playing_q  <= 1'b0;
      new_best_q <= 1'b0;
      hold_q     <= '0;
      start_q    <= 1'b0;
      pipe_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      gameover_q <= gameover_d;
      playing_q  <= playing_d;
      new_best_q <= new_best_d;
      hold_q     <= hold_d;
      start_q    <= start;
      pipe_q     <= pipe_pass;
    end
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign gameover   = gameover_q;
  assign playing    = playing_q;
  assign new_best   = new_best_q;

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-state and scoring controller for Flappy Bird.
- Produces the binary score and game-over flag consumed by the 7-segment score display.
- Sits between the pipe/collision logic and the display.
- Sequences IDLE -> PLAY -> OVER, counts pipe passes with saturation, tracks a session high score, and enforces a hold-off period after game over before a restart is accepted.

Parameters:
- SCORE_W, 10, width of score and high_score.
- MAX_SCORE, 999, saturation value of score (largest value the display renders).
- HOLD_CYCLES, 50000000, clk cycles in OVER before start is accepted (1 s at 50 MHz).
- HOLD_W, 26, width of hold-off counter; must hold HOLD_CYCLES-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  start/flap button, level, already synchronised to clk.
- pipe_pass  input  1  high while bird is past a pipe gap; a rising edge scores one point.
- collision  input  1  level, high while bird overlaps pipe/ground/ceiling.
- score  output  SCORE_W  current score, registered.
- gameover  output  1  high in OVER, registered.
- playing  output  1  high in PLAY, registered.
- high_score  output  SCORE_W  best score since reset, registered.
- new_best  output  1  high in OVER when the finished game set a new high score.

Behaviour:
Reset (asynchronous, active-high):
- state=IDLE; score=0, high_score=0, gameover=0, playing=0, new_best=0.
- hold counter=0; start_q=0, pipe_q=0.
- Reset asserted mid-game aborts the game immediately and also clears high_score.

Edge detection:
- start_q and pipe_q register start and pipe_pass every cycle.
- start_rise = start & ~start_q; pipe_rise = pipe_pass & ~pipe_q.
- Held levels never generate repeat events.

All outputs are registered and reflect state after the active edge.

IDLE:
- playing=0, gameover=0, score holds 0.
- collision and pipe_pass are ignored.
- start_rise -> PLAY at that edge; score<=0, new_best<=0.

PLAY (playing=1):
- collision=1 -> OVER at that edge, taking priority over pipe_rise in the same cycle (no increment).
- On entering OVER:
  - gameover<=1, playing<=0.
  - hold counter<=HOLD_CYCLES-1.
  - If score > high_score: high_score<=score and new_best<=1; else new_best<=0.
  - Equal score does not set new_best.
- pipe_rise without collision: score<=score+1 if score<MAX_SCORE, else score holds MAX_SCORE. Never wraps.
- start_rise in PLAY has no effect on this block (flap handled elsewhere).

OVER (gameover=1):
- score, high_score and new_best are frozen; pipe_pass and collision are ignored.
- Hold counter decrements by 1 per cycle down to 0, then holds.
- start_rise while counter != 0 is ignored and consumed; a held button must be released and re-pressed.
- start_rise while counter == 0 -> PLAY: score<=0, gameover<=0, new_best<=0, playing<=1. high_score retained.

General:
- Latency: the score change is visible the cycle after the edge at which pipe_pass is first sampled high.
- gameover rises the cycle after the edge at which collision is first sampled high in PLAY.
- HOLD_CYCLES=1 permits restart on the first start_rise after the OVER-entry edge.
- No illegal state may lock up; unused encodings return to IDLE.

Test Plan:
1. Reset, then start pulse: IDLE -> PLAY. Then 5 separate pipe_pass pulses (2 cycles high each) -> score=5, playing=1; a pipe_pass held 20 cycles adds exactly 1.
2. In PLAY with score=7, assert collision and pipe_pass rising in the same cycle -> next cycle gameover=1, score=7, high_score=7, new_best=1.
3. Preload score to 998 via pulses, then 3 more pulses -> score=999 and stays 999. Then collision -> high_score=999.
4. HOLD_CYCLES=8: in OVER, start pulse at cycle 3 -> ignored, still OVER. Start held through cycle 10 -> still OVER. Release, then re-press at cycle 12 -> PLAY, score=0, gameover=0, high_score retained.
5. Second game ends with score 4 < high_score 7 -> high_score=7, new_best=0. A game ending at exactly 7 -> new_best=0.
6. Assert reset asynchronously mid-PLAY with score=3 and high_score=9 -> all outputs 0 immediately, state IDLE. Collision in IDLE -> no change.
